example_03_driver: RTL and testbench

Stimulus initiator for the example_03 sequence detector. On a `start` request it drives `A`, `B`, `C` and `D` through the four-step unlock sequence: A, D=0100, A&B, D=1000. It advances one step only after the detector's `Q` shows the expected code, with a per-step timeout. The block sits in the same clock domain as the detector: its outputs feed the detector inputs and the detector's `Q` feeds back into `Q_in`.

---
 rtl/example_03_driver.sv | 136 +++++++++++++
 tb/tb_example_03_driver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/example_03_driver.sv
// Stimulus initiator for the example_03 sequence detector: walks A, D=KEY1, A&B, D=KEY2,
// advancing on each expected Q code and failing a step that does not match within TIMEOUT cycles.
module example_03_driver #(
    parameter int         TIMEOUT = 16,
    parameter logic [3:0] D_KEY1  = 4'b0100,
    parameter logic [3:0] D_KEY2  = 4'b1000
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       start,
    input  logic [2:0] Q_in,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic [3:0] D,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [2:0] fail_step
);

    typedef enum logic [2:0] {
        IDLE, ARM, KEY1, KEY2, KEY3, DONE, FAIL
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] step_cnt_q, step_cnt_d;
    logic [2:0] fail_step_q, fail_step_d;
    logic       a_q, a_d, b_q, b_d, busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic [3:0] d_q, d_d;
    logic [2:0] exp_code, step_num;
    state_t     next_step;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= IDLE;
            step_cnt_q  <= '0;
            fail_step_q <= '0;
        end else begin
            state_q     <= state_d;
            step_cnt_q  <= step_cnt_d;
            fail_step_q <= fail_step_d;
        end
    end

    always_comb begin
        exp_code  = 3'b000;
        step_num  = 3'd0;
        next_step = IDLE;
        case (state_q)
            ARM:     begin exp_code = 3'b011; step_num = 3'd1; next_step = KEY1; end
            KEY1:    begin exp_code = 3'b100; step_num = 3'd2; next_step = KEY2; end
            KEY2:    begin exp_code = 3'b000; step_num = 3'd3; next_step = KEY3; end
            KEY3:    begin exp_code = 3'b111; step_num = 3'd4; next_step = DONE; end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        step_cnt_d  = step_cnt_q;
        fail_step_d = fail_step_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ARM;
                    step_cnt_d  = '0;
                    fail_step_d = '0;
                end
            end
            ARM, KEY1, KEY2, KEY3: begin
                // a match in the last allowed cycle still advances
                if (Q_in == exp_code) begin
                    state_d    = next_step;
                    step_cnt_d = '0;
                end else if (step_cnt_q == CNT_MAX) begin
                    state_d     = FAIL;
                    step_cnt_d  = '0;
                    fail_step_d = step_num;
                end else begin
                    step_cnt_d = step_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // outputs decoded from the next state so they are flops aligned with the state
    always_comb begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        d_d    = 4'b0000;
        busy_d = 1'b0;
        done_d = 1'b0;
        fail_d = 1'b0;
        case (state_d)
            ARM:     begin a_d = 1'b1; busy_d = 1'b1; end
            KEY1:    begin d_d = D_KEY1; busy_d = 1'b1; end
            KEY2:    begin a_d = 1'b1; b_d = 1'b1; busy_d = 1'b1; end
            KEY3:    begin d_d = D_KEY2; busy_d = 1'b1; end
            DONE:    done_d = 1'b1;
            FAIL:    fail_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            d_q    <= 4'b0000;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            d_q    <= d_d;
            busy_q <= busy_d;
            done_q <= done_d;
            fail_q <= fail_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign C         = 1'b0;
    assign D         = d_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_step = fail_step_q;

endmodule

// File: tb/tb_example_03_driver.sv
// Bench for example_03_driver: vector table, directed corner sequences with a detector stand-in,
// and random start/Q traffic checked cycle by cycle against a step-level reference model.
module tb_example_03_driver;

    localparam int T0 = 16;

    logic       clk = 1'b0;
    logic       rstN, start, start1, mode, force_en, dly2, chk_en;
    logic [2:0] q_drv, q_in0, q_in1, det_q, s1, s2, s3;
    logic       A0, B0, C0, busy0, done0, fail0;
    logic [3:0] D0;
    logic [2:0] fs0;
    logic       A1, B1, C1, busy1, done1, fail1;
    logic [3:0] D1;
    logic [2:0] fs1;
    int         tests = 0, fails = 0;
    int         m_step, m_cnt;
    logic [2:0] m_fs;

    always #5 clk = ~clk;

    example_03_driver #(.TIMEOUT(T0)) dut0 (
        .clk(clk), .rstN(rstN), .start(start), .Q_in(q_in0),
        .A(A0), .B(B0), .C(C0), .D(D0), .busy(busy0), .done(done0), .fail(fail0), .fail_step(fs0)
    );

    example_03_driver #(.TIMEOUT(3)) dut1 (
        .clk(clk), .rstN(rstN), .start(start1), .Q_in(q_in1),
        .A(A1), .B(B1), .C(C1), .D(D1), .busy(busy1), .done(done1), .fail(fail1), .fail_step(fs1)
    );

    // detector stand-in: Q reflects the last pattern seen, neutral returns it to 000
    function automatic logic [2:0] det_f(input logic a, input logic b, input logic [3:0] d);
        if (a && b)            return 3'b000;
        else if (a)            return 3'b011;
        else if (d == 4'b0100) return 3'b100;
        else if (d == 4'b1000) return 3'b111;
        else                   return 3'b000;
    endfunction

    always @(posedge clk or negedge rstN)
        if (!rstN) det_q <= 3'b000;
        else       det_q <= det_f(A0, B0, D0);

    always @(posedge clk or negedge rstN)
        if (!rstN) begin s1 <= 3'b000; s2 <= 3'b000; s3 <= 3'b000; end
        else begin s1 <= det_f(A1, B1, D1); s2 <= s1; s3 <= s2; end

    assign q_in0 = (force_en && D0 == 4'b1000) ? 3'b100 : (mode ? det_q : q_drv);
    assign q_in1 = dly2 ? s3 : s2;

    function automatic logic [2:0] code_of(input int s);
        case (s)
            1:       return 3'b011;
            2:       return 3'b100;
            3:       return 3'b000;
            default: return 3'b111;
        endcase
    endfunction

    // reference: step 0 idle, 1..4 sequence steps, 5 done, 6 fail
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m_step <= 0; m_cnt <= 0; m_fs <= 3'd0;
        end else if (m_step == 0) begin
            if (start) begin m_step <= 1; m_cnt <= 0; m_fs <= 3'd0; end
        end else if (m_step <= 4) begin
            if (q_in0 == code_of(m_step)) begin
                m_step <= m_step + 1; m_cnt <= 0;
            end else if (m_cnt == T0 - 1) begin
                m_step <= 6; m_fs <= 3'(m_step);
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else begin
            m_step <= 0;
        end
    end

    function automatic logic [12:0] mk(input logic a, input logic b, input logic [3:0] d,
                                       input logic bz, input logic dn, input logic fl,
                                       input logic [2:0] fs);
        return {a, b, 1'b0, d, bz, dn, fl, fs};
    endfunction

    function automatic logic [12:0] model_out();
        logic [3:0] d;
        d = (m_step == 2) ? 4'b0100 : (m_step == 4) ? 4'b1000 : 4'b0000;
        return mk(m_step == 1 || m_step == 3, m_step == 3, d, m_step >= 1 && m_step <= 4,
                  m_step == 5, m_step == 6, m_fs);
    endfunction

    wire [12:0] pack0 = {A0, B0, C0, D0, busy0, done0, fail0, fs0};
    wire [12:0] pack1 = {A1, B1, C1, D1, busy1, done1, fail1, fs1};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (chk_en) chk("model", 32'(pack0), 32'(model_out()));

    typedef struct {
        logic        start;
        logic [2:0]  q;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int n, dcnt, dedge;
        logic seen_fail;

        tbl[0]  = '{1'b1, 3'b000, mk(1, 0, 4'b0000, 1, 0, 0, 3'd0)};
        tbl[1]  = '{1'b0, 3'b000, mk(1, 0, 4'b0000, 1, 0, 0, 3'd0)};
        tbl[2]  = '{1'b0, 3'b011, mk(0, 0, 4'b0100, 1, 0, 0, 3'd0)};
        tbl[3]  = '{1'b0, 3'b011, mk(0, 0, 4'b0100, 1, 0, 0, 3'd0)};
        tbl[4]  = '{1'b0, 3'b100, mk(1, 1, 4'b0000, 1, 0, 0, 3'd0)};
        tbl[5]  = '{1'b0, 3'b100, mk(1, 1, 4'b0000, 1, 0, 0, 3'd0)};
        tbl[6]  = '{1'b0, 3'b000, mk(0, 0, 4'b1000, 1, 0, 0, 3'd0)};
        tbl[7]  = '{1'b0, 3'b000, mk(0, 0, 4'b1000, 1, 0, 0, 3'd0)};
        tbl[8]  = '{1'b0, 3'b111, mk(0, 0, 4'b0000, 0, 1, 0, 3'd0)};
        tbl[9]  = '{1'b0, 3'b111, mk(0, 0, 4'b0000, 0, 0, 0, 3'd0)};
        tbl[10] = '{1'b0, 3'b111, mk(0, 0, 4'b0000, 0, 0, 0, 3'd0)};

        rstN = 1'b0; start = 1'b0; start1 = 1'b0; q_drv = 3'b000;
        mode = 1'b0; force_en = 1'b0; dly2 = 1'b0; chk_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset0", 32'(pack0), 32'd0);
        chk("reset1", 32'(pack1), 32'd0);
        rstN = 1'b1; chk_en = 1'b1;
        @(negedge clk);

        // full run, conforming Q timeline driven directly
        for (int i = 0; i < 11; i++) begin
            start = tbl[i].start; q_drv = tbl[i].q;
            @(negedge clk);
            chk($sformatf("tbl%0d", i), 32'(pack0), 32'(tbl[i].exp));
        end

        // ARM timeout with Q stuck at 000
        q_drv = 3'b000; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 15) chk("to_nofail15", 32'(fail0), 32'd0);
            if (k == 16) chk("to_fail16", 32'({fail0, fs0}), 32'({1'b1, 3'd1}));
            if (k == 17) chk("to_hold17", 32'({fail0, busy0, fs0}), 32'({1'b0, 1'b0, 3'd1}));
        end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("to_clear", 32'({busy0, fs0}), 32'({1'b1, 3'd0}));
        repeat (20) @(negedge clk);

        // KEY3 forced wrong: fails 16 cycles after KEY3 entry at edge 6
        mode = 1'b1; force_en = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (n < 40 && !fail0) begin @(negedge clk); n++; end
        chk("k3_fail_edge", 32'(n), 32'd22);
        chk("k3_fail_step", 32'({fs0, D0}), 32'({3'd4, 4'b0000}));
        force_en = 1'b0;
        @(negedge clk);
        chk("k3_idle", 32'({busy0, D0, fs0}), 32'({1'b0, 4'b0000, 3'd4}));

        // start spam while busy
        start = 1'b1;
        @(negedge clk);
        dcnt = 0; dedge = 0;
        for (int k = 1; k <= 14; k++) begin
            start = (k <= 7) ? k[0] : 1'b0;
            @(negedge clk);
            if (done0) begin dcnt++; dedge = k; end
        end
        chk("spam_done_cnt", 32'(dcnt), 32'd1);
        chk("spam_done_edge", 32'(dedge), 32'd8);

        // start held high: earliest restart lands 2 edges after the last step
        start = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k == 8)  chk("b2b_done", 32'({done0, busy0}), 32'({1'b1, 1'b0}));
            if (k == 9)  chk("b2b_idle", 32'({done0, busy0}), 32'd0);
            if (k == 10) chk("b2b_rearm", 32'({busy0, A0}), 32'({1'b1, 1'b1}));
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        // asynchronous reset mid-KEY1
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_key1", 32'(D0), 32'(4'b0100));
        #2 rstN = 1'b0;
        #1 chk("async_rst", 32'(pack0), 32'd0);
        @(negedge clk); rstN = 1'b1;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (n < 20 && !done0) begin @(negedge clk); n++; end
        chk("post_rst_done", 32'(n), 32'd8);

        // TIMEOUT=3: match in the third cycle of each step must advance
        start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        seen_fail = 1'b0; dedge = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (fail1) seen_fail = 1'b1;
            if (done1) dedge = k;
            if (k == 2) chk("tie_arm2", 32'({A1, busy1}), 32'({1'b1, 1'b1}));
            if (k == 3) chk("tie_key1", 32'(D1), 32'(4'b0100));
        end
        chk("tie_nofail", 32'(seen_fail), 32'd0);
        chk("tie_done_edge", 32'(dedge), 32'd12);

        // one cycle too late fails step 1
        dly2 = 1'b1; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 3) chk("late_fail", 32'({fail1, fs1}), 32'({1'b1, 3'd1}));
        end
        dly2 = 1'b0;

        // random start / Q traffic against the model
        mode = 1'b0;
        for (int k = 0; k < 800; k++) begin
            start = ($urandom % 6) == 0;
            if (m_step >= 1 && m_step <= 4 && ($urandom % 3) == 0) q_drv = code_of(m_step);
            else q_drv = 3'($urandom % 8);
            @(negedge clk);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
